dmem_arbiter: RTL and testbench

//  Shares the single-port DataMemory between the MIPS datapath (lw/sw) and the

---
 rtl/dmem_arbiter.sv | 111 +++++++++++
 tb/tb_dmem_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - DataMemory arbiter between CPU and user port; define DMEM_ARB_STATS_EN to add stall_cnt
module dmem_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          usr_req,
    input  logic          usr_we,
    input  logic [AW-1:0] usr_addr,
    input  logic [DW-1:0] usr_wdata,
    output logic          usr_busy,
    output logic          usr_done,
    output logic [DW-1:0] usr_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
`ifdef DMEM_ARB_STATS_EN
    output logic [15:0]   stall_cnt,
`endif
    input  logic [DW-1:0] mem_rdata
);

    // MAX_WAIT=0 still needs a one-bit counter that simply stays at zero
    localparam int             WCW      = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

    typedef enum logic [1:0] {
        U_IDLE,
        U_PEND,
        U_DONE
    } u_state_t;

    u_state_t       state;
    logic [WCW-1:0] wait_cnt;
    logic           usr_we_q;
    logic [AW-1:0]  usr_addr_q;
    logic [DW-1:0]  usr_wdata_q;
    logic           usr_gnt;

    // CPU owns the memory unless it is idle or the user has waited long enough;
    // reset blocks any grant so a pending user write is dropped
    assign usr_gnt   = !rst && (state == U_PEND) && (!cpu_req || (wait_cnt == WAIT_MAX));
    assign cpu_stall = cpu_req && usr_gnt;
    assign usr_busy  = (state != U_IDLE);
    assign usr_done  = (state == U_DONE);
    assign cpu_rdata = mem_rdata;
    assign mem_addr  = usr_gnt ? usr_addr_q  : cpu_addr;
    assign mem_wdata = usr_gnt ? usr_wdata_q : cpu_wdata;
    assign mem_we    = !rst && (usr_gnt ? usr_we_q : (cpu_req && cpu_we));

    // User request FSM: latch on accept, wait for grant, one-cycle done
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= U_IDLE;
            wait_cnt    <= '0;
            usr_rdata   <= '0;
            usr_we_q    <= 1'b0;
            usr_addr_q  <= '0;
            usr_wdata_q <= '0;
        end else begin
            case (state)
                U_IDLE: begin
                    wait_cnt <= '0;
                    if (usr_req) begin
                        state       <= U_PEND;
                        usr_we_q    <= usr_we;
                        usr_addr_q  <= usr_addr;
                        usr_wdata_q <= usr_wdata;
                    end
                end
                U_PEND: begin
                    if (usr_gnt) begin
                        state    <= U_DONE;
                        wait_cnt <= '0;
                        if (!usr_we_q) begin
                            usr_rdata <= mem_rdata;
                        end
                    end else if (wait_cnt != WAIT_MAX) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                U_DONE: begin
                    state <= U_IDLE;
                end
                default: begin
                    state <= U_IDLE;
                end
            endcase
        end
    end

`ifdef DMEM_ARB_STATS_EN
    // Saturating count of cycles in which the CPU was held off
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (cpu_stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;

    localparam int MW = 4;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [7:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        usr_req;
    logic        usr_we;
    logic [7:0]  usr_addr;
    logic [31:0] usr_wdata;
    logic        usr_busy;
    logic        usr_done;
    logic [31:0] usr_rdata;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stall_cnt;
`endif

    dmem_arbiter #(.AW(8), .DW(32), .MAX_WAIT(MW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .usr_req   (usr_req),
        .usr_we    (usr_we),
        .usr_addr  (usr_addr),
        .usr_wdata (usr_wdata),
        .usr_busy  (usr_busy),
        .usr_done  (usr_done),
        .usr_rdata (usr_rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
`ifdef DMEM_ARB_STATS_EN
        .stall_cnt (stall_cnt),
`endif
        .mem_rdata (mem_rdata)
    );

    // DataMemory: async read, write on rising edge
    logic [31:0] mem [256];
    logic        mem_fill;

    function automatic logic [31:0] init_word(input int i);
        return (i * 32'h0101_0101) ^ 32'hA5A5_0000;
    endfunction

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_fill) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // Reference model: transaction-level view of the arbitration rules
    typedef struct {
        logic        stall;
        logic        busy;
        logic        done;
        logic        we;
        logic        chk_rd;
        logic [31:0] rd;
    } cyc_rec_t;

    typedef struct {
        int          cyc;
        int          acc_cyc;
        logic [31:0] rdata;
    } done_rec_t;

    cyc_rec_t    cyc_q[$];
    done_rec_t   done_q[$];
    logic [31:0] ref_mem [256];

    logic        m_pend    = 1'b0;
    logic        m_done    = 1'b0;
    int          m_lost    = 0;
    int          m_acc     = 0;
    logic        m_we      = 1'b0;
    logic [7:0]  m_addr    = '0;
    logic [31:0] m_wdata   = '0;
    logic [31:0] m_last_rd = '0;
    int          m_stalls  = 0;

    task automatic model_cycle();
        cyc_rec_t  c;
        done_rec_t d;
        logic      gnt;
        logic      acc;
        gnt      = !rst && m_pend && (!cpu_req || (m_lost == MW));
        c.stall  = cpu_req && gnt;
        c.busy   = m_pend || m_done;
        c.done   = m_done;
        c.we     = !rst && (gnt ? m_we : (cpu_req && cpu_we));
        c.chk_rd = !rst && cpu_req && !cpu_we && !gnt;
        c.rd     = ref_mem[cpu_addr];
        cyc_q.push_back(c);
        if (rst) begin
            m_pend    = 1'b0;
            m_done    = 1'b0;
            m_lost    = 0;
            m_last_rd = '0;
            m_stalls  = 0;
        end else begin
            acc = usr_req && !(m_pend || m_done);
            if (gnt) begin
                if (!m_we) m_last_rd = ref_mem[m_addr];
                else       ref_mem[m_addr] = m_wdata;
                d.cyc     = cyc + 1;
                d.acc_cyc = m_acc;
                d.rdata   = m_last_rd;
                done_q.push_back(d);
            end else if (cpu_req && cpu_we) begin
                ref_mem[cpu_addr] = cpu_wdata;
            end
            if (c.stall && m_stalls < 65535) m_stalls++;
            if (m_pend && !gnt && m_lost < MW) m_lost++;
            m_done = gnt;
            if (gnt) m_pend = 1'b0;
            if (acc) begin
                m_pend  = 1'b1;
                m_lost  = 0;
                m_acc   = cyc;
                m_we    = usr_we;
                m_addr  = usr_addr;
                m_wdata = usr_wdata;
            end
        end
    endtask

    // Monitor: compare every modelled cycle and every usr_done pulse
    always @(negedge clk) begin
        cyc_rec_t  c;
        done_rec_t d;
        if (cyc_q.size() > 0) begin
            c = cyc_q.pop_front();
            chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, c.stall});
            chk("usr_busy",  {31'd0, usr_busy},  {31'd0, c.busy});
            chk("usr_done",  {31'd0, usr_done},  {31'd0, c.done});
            chk("mem_we",    {31'd0, mem_we},    {31'd0, c.we});
            if (c.chk_rd) chk("cpu_rdata", cpu_rdata, c.rd);
        end
        if (usr_done === 1'b1 && done_q.size() > 0) begin
            d = done_q.pop_front();
            chk("usr_done_cycle", cyc, d.cyc);
            chk("usr_latency_bound", {31'd0, (d.cyc - d.acc_cyc) <= MW + 2}, 32'd1);
            chk("usr_rdata", usr_rdata, d.rdata);
        end
    end

    task automatic step(input logic r, input logic cr, input logic cw, input logic [7:0] ca,
                        input logic [31:0] cd, input logic ur, input logic uw,
                        input logic [7:0] ua, input logic [31:0] ud);
        rst       = r;
        cpu_req   = cr;
        cpu_we    = cw;
        cpu_addr  = ca;
        cpu_wdata = cd;
        usr_req   = ur;
        usr_we    = uw;
        usr_addr  = ua;
        usr_wdata = ud;
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
    endtask

    logic [31:0] saved;
    int          bad_words;

    initial begin
        rst = 1'b1; mem_fill = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        usr_req = 1'b0; usr_we = 1'b0; usr_addr = '0; usr_wdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

        // Reset held two cycles
        repeat (2) @(posedge clk);
        #1;
        mem_fill = 1'b0;
        chk("rst_usr_busy",  {31'd0, usr_busy},  32'd0);
        chk("rst_usr_done",  {31'd0, usr_done},  32'd0);
        chk("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
        chk("rst_mem_we",    {31'd0, mem_we},    32'd0);
        chk("rst_usr_rdata", usr_rdata, 32'd0);

        // User write with idle CPU, then read it back
        step(1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b1, 1'b1, 8'h10, 32'hABC);
        idle(3);
        chk("s2_mem_word", mem[8'h10], 32'hABC);
        step(1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b1, 1'b0, 8'h10, 32'h0);
        idle(3);
        chk("s2_readback", usr_rdata, 32'hABC);

        // User read under continuous CPU traffic, three times
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 1'b0, 8'h3, 32'h0, 1'b1, 1'b0, 8'h5, 32'h0);
            for (int i = 0; i < MW + 3; i++) step(1'b0, 1'b1, 1'b0, 8'(i), 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
        end
`ifdef DMEM_ARB_STATS_EN
        chk("s6_stall_cnt", {16'd0, stall_cnt}, 32'd3);
`endif

        // Same-cycle CPU store and user read of one address
        step(1'b0, 1'b1, 1'b1, 8'h20, 32'h55, 1'b1, 1'b0, 8'h20, 32'h0);
        idle(3);
        chk("s4_cpu_first", usr_rdata, 32'h55);

        // Reset drops a pending user write
        saved = mem[8'h30];
        step(1'b0, 1'b1, 1'b0, 8'h1, 32'h0, 1'b1, 1'b1, 8'h30, 32'hDEAD_BEEF);
        step(1'b0, 1'b1, 1'b0, 8'h2, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 8'h2, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
        chk("s5_busy_after_rst", {31'd0, usr_busy}, 32'd0);
        idle(2);
        chk("s5_word_unchanged", mem[8'h30], saved);

        // Randomized traffic, alternating heavy and light CPU load
        for (int i = 0; i < 3000; i++) begin
            int load;
            load = ((i / 400) % 2 == 0) ? 90 : 30;
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 99) < load), 1'($urandom), 8'($urandom_range(0, 15)), $urandom,
                 ($urandom_range(0, 99) < 50), 1'($urandom), 8'($urandom_range(0, 15)), $urandom);
        end
        idle(MW + 4);

        chk("done_queue_drained", done_q.size(), 32'd0);
        bad_words = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad_words++;
        chk("final_memory", bad_words, 32'd0);
`ifdef DMEM_ARB_STATS_EN
        chk("stall_cnt_final", {16'd0, stall_cnt}, 32'(m_stalls));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
